// File: rtl/ivl_uvm_ovl_no_trans_multi_pkg.sv
`timescale 1ns/1ps
// Shared state encoding, severity constant and saturating-increment helper
// for the ivl_uvm OVL no-transition checkers.
package ivl_uvm_ovl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HALT  = 2'd2
  } ovl_nt_state_e;

  localparam int OVL_SEV_ERROR = 1;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_val;
    max_val = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_val) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ivl_uvm_ovl_no_trans_multi_if.sv
`timescale 1ns/1ps
// Signal bundle between a bench (master) and the multi-pair no-transition
// checker (slave).
interface ivl_uvm_ovl_no_trans_multi_if #(
  parameter int WIDTH     = 8,
  parameter int NUM_PAIRS = 4,
  parameter int CNT_W     = 16,
  parameter int PAIR_W    = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
);
  logic                       enable;
  logic                       clear;
  logic [WIDTH-1:0]           test_expr;
  logic [NUM_PAIRS*WIDTH-1:0] start_state;
  logic [NUM_PAIRS*WIDTH-1:0] next_state;
  logic [NUM_PAIRS-1:0]       fire;
  logic [CNT_W-1:0]           error_count;
  logic                       first_valid;
  logic [PAIR_W-1:0]          first_pair;
  logic [CNT_W-1:0]           cover_hits;

  modport master (
    output enable, clear, test_expr, start_state, next_state,
    input  fire, error_count, first_valid, first_pair, cover_hits
  );

  modport slave (
    input  enable, clear, test_expr, start_state, next_state,
    output fire, error_count, first_valid, first_pair, cover_hits
  );
endinterface

// File: rtl/ivl_uvm_ovl_no_trans_multi_pair_cmp.sv
`timescale 1ns/1ps
// One forbidden-pair comparator: holds the start state seen at the previous
// enabled edge and flags prev==start && test_expr==next (violation) plus a start hit.
module ivl_uvm_ovl_nt_pair_cmp
  import ivl_uvm_ovl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             capture,
  input  logic [WIDTH-1:0] start_state,
  input  logic [WIDTH-1:0] next_state,
  input  logic [WIDTH-1:0] test_expr,
  input  logic [WIDTH-1:0] prev,
  output logic             hit,
  output logic             viol
);
  logic [WIDTH-1:0] prev_start;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       prev_start <= '0;
    else if (capture) prev_start <= start_state;
  end

  // if-based compare so an X operand falls to the no-match branch
  always_comb begin
    hit  = 1'b0;
    viol = 1'b0;
    if (test_expr == start_state) hit = 1'b1;
    if ((prev == prev_start) && (test_expr == next_state)) viol = 1'b1;
  end
endmodule

// File: rtl/ivl_uvm_ovl_no_trans_multi.sv
`timescale 1ns/1ps
// Multi-pair forbidden-transition checker: registered per-pair fire (latency 1),
// saturating error count, first-violation capture, report limit. Optional macro OVL_NO_TRANS_COVER_EN.
module ivl_uvm_ovl_no_trans_multi
  import ivl_uvm_ovl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_PAIRS  = 4,
  parameter int CNT_W      = 16,
  parameter int MAX_REPORT = 0,
  parameter     MSG        = "VIOLATION"
) (
  input logic clock,
  input logic reset,
  ivl_uvm_ovl_no_trans_multi_if.slave bus
);
  localparam int PAIR_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ARMED = ARMED;
  localparam logic [1:0] S_HALT  = HALT;

  logic [1:0]           state;
  logic [WIDTH-1:0]     prev;
  logic [NUM_PAIRS-1:0] hit_vec;
  logic [NUM_PAIRS-1:0] raw_vec;
  logic [NUM_PAIRS-1:0] viol_vec;
  logic [CNT_W-1:0]     reported;
  logic                 any_viol;
  logic                 report;
  logic                 at_limit;
  logic [PAIR_W-1:0]    low_idx;

  for (genvar g = 0; g < NUM_PAIRS; g++) begin : g_pair
    ivl_uvm_ovl_nt_pair_cmp #(.WIDTH(WIDTH)) u_cmp (
      .clock       (clock),
      .reset       (reset),
      .capture     (bus.enable),
      .start_state (bus.start_state[g*WIDTH +: WIDTH]),
      .next_state  (bus.next_state[g*WIDTH +: WIDTH]),
      .test_expr   (bus.test_expr),
      .prev        (prev),
      .hit         (hit_vec[g]),
      .viol        (raw_vec[g])
    );
  end

  assign viol_vec = ((state != S_IDLE) && bus.enable) ? raw_vec : '0;
  assign any_viol = |viol_vec;
  assign report   = any_viol && (state == S_ARMED) && !bus.clear;
  assign at_limit = (MAX_REPORT != 0) &&
                    ((32'(reported) + 32'd1) == 32'(MAX_REPORT));

  always_comb begin
    low_idx = '0;
    for (int i = NUM_PAIRS - 1; i >= 0; i--)
      if (viol_vec[i]) low_idx = PAIR_W'(i);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          prev <= '0;
    else if (bus.enable) prev <= bus.test_expr;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      bus.fire        <= '0;
      bus.error_count <= '0;
      bus.first_valid <= 1'b0;
      bus.first_pair  <= '0;
      reported        <= '0;
    end else if (bus.clear) begin
      state           <= S_IDLE;
      bus.fire        <= '0;
      bus.error_count <= '0;
      bus.first_valid <= 1'b0;
      bus.first_pair  <= '0;
      reported        <= '0;
    end else begin
      bus.fire <= report ? viol_vec : '0;
      if (any_viol)
        bus.error_count <= CNT_W'(sat_inc(32'(bus.error_count), CNT_W));
      if (any_viol && !bus.first_valid) begin
        bus.first_valid <= 1'b1;
        bus.first_pair  <= low_idx;
      end
      if (report)
        reported <= CNT_W'(sat_inc(32'(reported), CNT_W));
      case (state)
        S_IDLE:  if (bus.enable) state <= S_ARMED;
        S_ARMED: begin
          if (!bus.enable)          state <= S_IDLE;
          else if (report && at_limit) state <= S_HALT;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef OVL_NO_TRANS_COVER_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                        bus.cover_hits <= '0;
    else if (bus.clear)                bus.cover_hits <= '0;
    else if (bus.enable && |hit_vec)
      bus.cover_hits <= CNT_W'(sat_inc(32'(bus.cover_hits), CNT_W));
  end
`else
  logic unused_hits;
  assign unused_hits    = ^hit_vec;
  assign bus.cover_hits = '0;
`endif

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (reset && report)
      for (int i = 0; i < NUM_PAIRS; i++)
        if (viol_vec[i])
          $display("OVL_ERROR %s pair=%0d %h->%h t=%0t", MSG, i, prev, bus.test_expr, $time);
  end
`endif
endmodule

// File: tb/tb_ivl_uvm_ovl_no_trans_multi.sv
`timescale 1ns/1ps
// Scoreboard bench for ivl_uvm_ovl_no_trans_multi (MAX_REPORT=2, 4 pairs of 8 bits).
module tb_ivl_uvm_ovl_no_trans_multi;
  import ivl_uvm_ovl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ivl_uvm_ovl_no_trans_multi_if #(.WIDTH(8), .NUM_PAIRS(4), .CNT_W(16)) bus ();

  ivl_uvm_ovl_no_trans_multi #(
    .WIDTH(8), .NUM_PAIRS(4), .CNT_W(16), .MAX_REPORT(2), .MSG("VIOLATION")
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  fire;
    logic [15:0] cnt;
    logic        fv;
    logic [1:0]  fp;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  // Monitor: outputs settle 1 ns after each edge; compare with the oldest expectation.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("fire",        32'(bus.fire),        32'(e.fire));
      chk("error_count", 32'(bus.error_count), 32'(e.cnt));
      chk("first_valid", 32'(bus.first_valid), 32'(e.fv));
      chk("first_pair",  32'(bus.first_pair),  32'(e.fp));
    end
  end

  task automatic step(input logic en, input logic clr, input logic [7:0] te,
                      input logic [3:0] f, input logic [15:0] c,
                      input logic fv, input logic [1:0] fp);
    @(negedge clk);
    bus.enable    = en;
    bus.clear     = clr;
    bus.test_expr = te;
    sb.push_back('{fire: f, cnt: c, fv: fv, fp: fp});
  endtask

  task automatic set_pairs(input logic [7:0] s0, input logic [7:0] n0,
                           input logic [7:0] s1, input logic [7:0] n1);
    bus.start_state = {8'hCC, 8'hAA, s1, s0};
    bus.next_state  = {8'hDD, 8'hBB, n1, n0};
  endtask

  task automatic chk_state(input logic [1:0] s, input string name);
    @(posedge clk);
    #1;
    chk(name, 32'(dut.state), 32'(s));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_fire"},  32'(bus.fire),        32'd0);
    chk({tag, "_cnt"},   32'(bus.error_count), 32'd0);
    chk({tag, "_fv"},    32'(bus.first_valid), 32'd0);
    chk({tag, "_fp"},    32'(bus.first_pair),  32'd0);
    chk({tag, "_cover"}, 32'(bus.cover_hits),  32'd0);
  endtask

  initial begin
    logic [15:0] exp_cover;
    bus.enable    = 1'b0;
    bus.clear     = 1'b0;
    bus.test_expr = 8'h00;
    set_pairs(8'h01, 8'h02, 8'h10, 8'h11);
    #12;
    chk_zero("reset");
    chk("reset_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Basic 01->02 violation, one-cycle fire pulse
    step(1, 0, 8'h01, 4'h0, 16'd0, 0, 2'd0);
    step(1, 0, 8'h02, 4'h1, 16'd1, 1, 2'd0);
    step(1, 0, 8'h02, 4'h0, 16'd1, 1, 2'd0);
    step(1, 1, 8'h00, 4'h0, 16'd0, 0, 2'd0);
    // 01,03,02 is not a forbidden transition
    step(1, 0, 8'h01, 4'h0, 16'd0, 0, 2'd0);
    step(1, 0, 8'h03, 4'h0, 16'd0, 0, 2'd0);
    step(1, 0, 8'h02, 4'h0, 16'd0, 0, 2'd0);
    // Pairs 0 and 1 identical: both fire, one count
    set_pairs(8'h05, 8'h06, 8'h05, 8'h06);
    step(1, 1, 8'h00, 4'h0, 16'd0, 0, 2'd0);
    step(1, 0, 8'h05, 4'h0, 16'd0, 0, 2'd0);
    step(1, 0, 8'h06, 4'h3, 16'd1, 1, 2'd0);
    step(1, 0, 8'h00, 4'h0, 16'd1, 1, 2'd0);
    set_pairs(8'h01, 8'h02, 8'h10, 8'h11);
    step(1, 1, 8'h00, 4'h0, 16'd0, 0, 2'd0);
    // Disabled gap breaks the transition
    step(1, 0, 8'h01, 4'h0, 16'd0, 0, 2'd0);
    step(0, 0, 8'h01, 4'h0, 16'd0, 0, 2'd0);
    chk_state(IDLE, "state_gap_idle");
    step(0, 0, 8'h01, 4'h0, 16'd0, 0, 2'd0);
    step(1, 0, 8'h02, 4'h0, 16'd0, 0, 2'd0);
    chk_state(ARMED, "state_rearm");
    step(1, 0, 8'h10, 4'h0, 16'd0, 0, 2'd0);
    step(1, 0, 8'h11, 4'h2, 16'd1, 1, 2'd1);
    step(1, 1, 8'h00, 4'h0, 16'd0, 0, 2'd0);
    // Report limit of 2, third violation only counted
    step(1, 0, 8'h01, 4'h0, 16'd0, 0, 2'd0);
    step(1, 0, 8'h02, 4'h1, 16'd1, 1, 2'd0);
    step(1, 0, 8'h01, 4'h0, 16'd1, 1, 2'd0);
    step(1, 0, 8'h02, 4'h1, 16'd2, 1, 2'd0);
    chk_state(HALT, "state_halt");
    step(1, 0, 8'h01, 4'h0, 16'd2, 1, 2'd0);
    step(1, 0, 8'h02, 4'h0, 16'd3, 1, 2'd0);
    chk_state(HALT, "state_halt_cnt");
    step(0, 0, 8'h02, 4'h0, 16'd3, 1, 2'd0);
    chk_state(HALT, "state_halt_dis");
    // Clear on the violating edge wins
    step(1, 1, 8'h00, 4'h0, 16'd0, 0, 2'd0);
    step(1, 0, 8'h01, 4'h0, 16'd0, 0, 2'd0);
    step(1, 1, 8'h02, 4'h0, 16'd0, 0, 2'd0);
    step(1, 0, 8'h01, 4'h0, 16'd0, 0, 2'd0);
    step(1, 0, 8'h02, 4'h1, 16'd1, 1, 2'd0);
    // Async reset while the fire pulse is high
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus.enable = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // prev/prev_start reset to 00 match pair0 start only if not re-armed first
    step(1, 0, 8'h02, 4'h0, 16'd0, 0, 2'd0);
    chk_state(ARMED, "state_arm_after_rst");
    // Start-state hits: 01,10,(disabled),01,55,10
    step(1, 1, 8'h00, 4'h0, 16'd0, 0, 2'd0);
    step(1, 0, 8'h01, 4'h0, 16'd0, 0, 2'd0);
    step(1, 0, 8'h10, 4'h0, 16'd0, 0, 2'd0);
    step(0, 0, 8'h01, 4'h0, 16'd0, 0, 2'd0);
    step(1, 0, 8'h01, 4'h0, 16'd0, 0, 2'd0);
    step(1, 0, 8'h55, 4'h0, 16'd0, 0, 2'd0);
    step(1, 0, 8'h10, 4'h0, 16'd0, 0, 2'd0);
`ifdef OVL_NO_TRANS_COVER_EN
    exp_cover = 16'd4;
`else
    exp_cover = 16'd0;
`endif
    @(posedge clk);
    #1;
    chk("cover_hits", 32'(bus.cover_hits), 32'(exp_cover));
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100us;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
